// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback
// and counts retired instructions. Define MCTRL_ILLEGAL_TRAP_EN to trap illegal opcodes.
module multicycle_ctrl #(
  parameter int RESET_STATE_FETCH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic [1:0]  alu_a_sel,
  output logic        alu_b_sel,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        trap
);

  if (RESET_STATE_FETCH != 1) begin : g_bad_reset_state
    $error("multicycle_ctrl: only RESET_STATE_FETCH=1 is supported");
  end

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  state_t      state_q, state_d;
  logic [31:0] instret_q;
  logic        legal;
  logic [1:0]  alu_a_op;
  logic        alu_b_op;

  // ALU operand selects by opcode; shared by EXEC and MEM so the address holds during a wait
  always_comb begin
    legal    = 1'b1;
    alu_a_op = 2'b00;
    alu_b_op = 1'b0;
    unique case (opcode)
      OP_R, OP_BRANCH, OP_JAL: ;
      OP_IMM, OP_LOAD, OP_STORE, OP_JALR: alu_b_op = 1'b1;
      OP_LUI: begin
        alu_a_op = 2'b10;
        alu_b_op = 1'b1;
      end
      OP_AUIPC: begin
        alu_a_op = 2'b01;
        alu_b_op = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src       = 2'b00;
    alu_a_sel    = 2'b00;
    alu_b_sel    = 1'b0;
    reg_we       = 1'b0;
    wb_sel       = 2'b00;
    unique case (state_q)
      FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
`ifdef MCTRL_ILLEGAL_TRAP_EN
        state_d = legal ? EXEC : TRAP;
`else
        state_d = EXEC;
`endif
      end
      EXEC: begin
        alu_a_sel = alu_a_op;
        alu_b_sel = alu_b_op;
        unique case (opcode)
          OP_LOAD, OP_STORE: state_d = MEM;
          OP_BRANCH: begin
            pc_we   = 1'b1;
            pc_src  = br_taken ? 2'b01 : 2'b00;
            state_d = FETCH;
          end
          OP_JAL: begin
            reg_we  = 1'b1;
            wb_sel  = 2'b10;
            pc_we   = 1'b1;
            pc_src  = 2'b01;
            state_d = FETCH;
          end
          OP_JALR: begin
            reg_we  = 1'b1;
            wb_sel  = 2'b10;
            pc_we   = 1'b1;
            pc_src  = 2'b10;
            state_d = FETCH;
          end
          default: state_d = WB;
        endcase
      end
      MEM: begin
        alu_a_sel    = alu_a_op;
        alu_b_sel    = alu_b_op;
        mem_req      = 1'b1;
        mem_addr_sel = 1'b1;
        mem_we       = (opcode == OP_STORE);
        if (mem_ready) begin
          if (opcode == OP_STORE) begin
            pc_we   = 1'b1;
            state_d = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      WB: begin
        reg_we  = legal;
        wb_sel  = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
        pc_we   = 1'b1;
        state_d = FETCH;
      end
      TRAP: state_d = TRAP;
      default: state_d = FETCH;
    endcase
    // Reset wins over the registered state, which only clears on the coming edge
    if (rst) begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_we        = 1'b0;
      pc_we        = 1'b0;
      pc_src       = 2'b00;
      alu_a_sel    = 2'b00;
      alu_b_sel    = 1'b0;
      reg_we       = 1'b0;
      wb_sel       = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instret_q <= '0;
    end else if (pc_we) begin
      instret_q <= instret_q + 32'd1;
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

`ifdef MCTRL_ILLEGAL_TRAP_EN
  assign trap = (state_q == TRAP) && !rst;
`else
  assign trap = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed scoreboard bench for multicycle_ctrl; expectations follow the
// MCTRL_ILLEGAL_TRAP_EN setting the design is built with.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_addr_sel, ir_we, pc_we, alu_b_sel, reg_we, trap;
  logic [1:0]  pc_src, alu_a_sel, wb_sel;
  logic [2:0]  state;
  logic [31:0] instret;

  multicycle_ctrl #(.RESET_STATE_FETCH(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr_sel(mem_addr_sel), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .state(state), .instret(instret), .trap(trap)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ILL    = 7'b0000000;

  typedef struct packed {
    logic [2:0] st;
    logic       req;
    logic       we;
    logic       asel;
    logic       irwe;
    logic       pcwe;
    logic [1:0] pcsrc;
    logic [1:0] a;
    logic       b;
    logic       regwe;
    logic [1:0] wb;
    logic       tr;
  } outs_t;

  typedef struct {
    string       tag;
    outs_t       outs;
    logic [31:0] ir;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned checks = 0;
  int unsigned failures = 0;
  logic [31:0] exp_instret = '0;

  function automatic outs_t mk(input logic [2:0] st, input logic req, input logic we,
                               input logic asel, input logic irwe, input logic pcwe,
                               input logic [1:0] pcsrc, input logic [1:0] a, input logic b,
                               input logic regwe, input logic [1:0] wb, input logic tr);
    outs_t o;
    o.st = st; o.req = req; o.we = we; o.asel = asel; o.irwe = irwe; o.pcwe = pcwe;
    o.pcsrc = pcsrc; o.a = a; o.b = b; o.regwe = regwe; o.wb = wb; o.tr = tr;
    return o;
  endfunction

  function automatic outs_t e_fetch(input logic rdy);
    return mk(3'd0, 1'b1, 1'b0, 1'b0, rdy, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
  endfunction

  function automatic outs_t e_idle(input logic [2:0] st);
    return mk(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0);
  endfunction

  task automatic cyc(input string tag, input logic r, input logic [6:0] op,
                     input logic bt, input logic rdy, input outs_t e);
    exp_t  it;
    outs_t obs;
    rst = r; opcode = op; br_taken = bt; mem_ready = rdy;
    sb_q.push_back('{tag, e, exp_instret});
    @(negedge clk);
    it = sb_q.pop_front();
    obs = mk(state, mem_req, mem_we, mem_addr_sel, ir_we, pc_we, pc_src,
             alu_a_sel, alu_b_sel, reg_we, wb_sel, trap);
    checks++;
    assert (obs === it.outs) else begin
      failures++;
      $error("FAIL %s outputs observed=%h expected=%h", it.tag, obs, it.outs);
    end
    checks++;
    assert (instret === it.ir) else begin
      failures++;
      $error("FAIL %s instret observed=%h expected=%h", it.tag, instret, it.ir);
    end
    if (r) exp_instret = '0;
    else if (e.pcwe) exp_instret = exp_instret + 32'd1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; opcode = '0; br_taken = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    cyc("reset", 1'b1, OP_R, 1'b0, 1'b1, e_idle(3'd0));

    // R-type: 0,1,2,4
    cyc("r_fetch", 1'b0, OP_R, 1'b0, 1'b1, e_fetch(1'b1));
    cyc("r_dec",   1'b0, OP_R, 1'b0, 1'b1, e_idle(3'd1));
    cyc("r_exec",  1'b0, OP_R, 1'b0, 1'b1, e_idle(3'd2));
    cyc("r_wb",    1'b0, OP_R, 1'b0, 1'b1,
        mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0));

    // LOAD with three MEM wait cycles
    cyc("ld_fetch", 1'b0, OP_LOAD, 1'b0, 1'b1, e_fetch(1'b1));
    cyc("ld_dec",   1'b0, OP_LOAD, 1'b0, 1'b1, e_idle(3'd1));
    cyc("ld_exec",  1'b0, OP_LOAD, 1'b0, 1'b1,
        mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0));
    for (int i = 0; i < 4; i++)
      cyc("ld_mem", 1'b0, OP_LOAD, 1'b0, (i == 3),
          mk(3'd3, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0));
    cyc("ld_wb", 1'b0, OP_LOAD, 1'b0, 1'b1,
        mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0));

    // STORE, no wait
    cyc("st_fetch", 1'b0, OP_STORE, 1'b0, 1'b1, e_fetch(1'b1));
    cyc("st_dec",   1'b0, OP_STORE, 1'b0, 1'b1, e_idle(3'd1));
    cyc("st_exec",  1'b0, OP_STORE, 1'b0, 1'b1,
        mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0));
    cyc("st_mem",   1'b0, OP_STORE, 1'b0, 1'b1,
        mk(3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0));

    // BRANCH taken then not taken
    for (int t = 1; t >= 0; t--) begin
      cyc("br_fetch", 1'b0, OP_BRANCH, t[0], 1'b1, e_fetch(1'b1));
      cyc("br_dec",   1'b0, OP_BRANCH, t[0], 1'b1, e_idle(3'd1));
      cyc("br_exec",  1'b0, OP_BRANCH, t[0], 1'b1,
          mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, {1'b0, t[0]}, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0));
    end

    // JAL and JALR
    cyc("jal_fetch", 1'b0, OP_JAL, 1'b0, 1'b1, e_fetch(1'b1));
    cyc("jal_dec",   1'b0, OP_JAL, 1'b0, 1'b1, e_idle(3'd1));
    cyc("jal_exec",  1'b0, OP_JAL, 1'b0, 1'b1,
        mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0));
    cyc("jalr_fetch", 1'b0, OP_JALR, 1'b0, 1'b1, e_fetch(1'b1));
    cyc("jalr_dec",   1'b0, OP_JALR, 1'b0, 1'b1, e_idle(3'd1));
    cyc("jalr_exec",  1'b0, OP_JALR, 1'b0, 1'b1,
        mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b00, 1'b1, 1'b1, 2'b10, 1'b0));

    // LUI with one FETCH wait, then AUIPC
    cyc("lui_fwait", 1'b0, OP_LUI, 1'b0, 1'b0, e_fetch(1'b0));
    cyc("lui_fetch", 1'b0, OP_LUI, 1'b0, 1'b1, e_fetch(1'b1));
    cyc("lui_dec",   1'b0, OP_LUI, 1'b0, 1'b1, e_idle(3'd1));
    cyc("lui_exec",  1'b0, OP_LUI, 1'b0, 1'b1,
        mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 1'b1, 1'b0, 2'b00, 1'b0));
    cyc("lui_wb",    1'b0, OP_LUI, 1'b0, 1'b1,
        mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0));
    cyc("auipc_fetch", 1'b0, OP_AUIPC, 1'b0, 1'b1, e_fetch(1'b1));
    cyc("auipc_dec",   1'b0, OP_AUIPC, 1'b0, 1'b1, e_idle(3'd1));
    cyc("auipc_exec",  1'b0, OP_AUIPC, 1'b0, 1'b1,
        mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0));
    cyc("auipc_wb",    1'b0, OP_AUIPC, 1'b0, 1'b1,
        mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0));

    // Illegal opcode
    cyc("ill_fetch", 1'b0, OP_ILL, 1'b0, 1'b1, e_fetch(1'b1));
    cyc("ill_dec",   1'b0, OP_ILL, 1'b0, 1'b1, e_idle(3'd1));
`ifdef MCTRL_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++)
      cyc("ill_trap", 1'b0, OP_ILL, 1'b0, 1'b1,
          mk(3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1));
    cyc("trap_rst", 1'b1, OP_ILL, 1'b0, 1'b1, e_idle(3'd5));
`else
    cyc("ill_exec", 1'b0, OP_ILL, 1'b0, 1'b1, e_idle(3'd2));
    cyc("ill_wb",   1'b0, OP_ILL, 1'b0, 1'b1,
        mk(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0));
`endif

    // Reset during a STORE MEM wait
    cyc("srst_fetch", 1'b0, OP_STORE, 1'b0, 1'b1, e_fetch(1'b1));
    cyc("srst_dec",   1'b0, OP_STORE, 1'b0, 1'b1, e_idle(3'd1));
    cyc("srst_exec",  1'b0, OP_STORE, 1'b0, 1'b1,
        mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0));
    cyc("srst_wait",  1'b0, OP_STORE, 1'b0, 1'b0,
        mk(3'd3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 2'b00, 1'b0));
    cyc("srst_rst",   1'b1, OP_STORE, 1'b0, 1'b1, e_idle(3'd3));
    cyc("srst_after", 1'b0, OP_STORE, 1'b0, 1'b0, e_fetch(1'b0));

    // instret wrap: preload all-ones while a branch sits in EXEC
    cyc("wrap_fetch", 1'b0, OP_BRANCH, 1'b0, 1'b1, e_fetch(1'b1));
    cyc("wrap_dec",   1'b0, OP_BRANCH, 1'b0, 1'b1, e_idle(3'd1));
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    exp_instret = 32'hFFFF_FFFF;
    cyc("wrap_exec",  1'b0, OP_BRANCH, 1'b0, 1'b1,
        mk(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0));
    cyc("wrap_after", 1'b0, OP_R, 1'b0, 1'b0, e_fetch(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control FSM for the RV32I core. It sequences a single shared datapath through fetch, decode, execute, memory and writeback. The datapath consists of the PC, instruction register, immediate generator, ALU, register file and a single memory port. The block drives every mux select and write strobe from the current state plus the opcode field of the instruction register. It also keeps a retired-instruction counter.

## Interface

Parameters:
- `RESET_STATE_FETCH`, 1: the FSM resets into FETCH. This is the only supported value.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `opcode`  in  7  `inst[6:0]` from the instruction register.
- `br_taken`  in  1  branch-condition result from the ALU, valid in EXEC.
- `mem_ready`  in  1  memory has completed the current request this cycle.
- `mem_req`  out  1  memory request strobe, held until `mem_ready`.
- `mem_we`  out  1  store request; valid only while `mem_req`=1.
- `mem_addr_sel`  out  1  0 = PC (fetch), 1 = ALU result (data access).
- `ir_we`  out  1  load the instruction register from memory read data.
- `pc_we`  out  1  update the PC.
- `pc_src`  out  2  00 = PC+4, 01 = PC+imm, 10 = {alu[31:1],1'b0}.
- `alu_a_sel`  out  2  00 = rs1, 01 = PC, 10 = zero.
- `alu_b_sel`  out  1  0 = rs2, 1 = imm.
- `reg_we`  out  1  register-file write enable.
- `wb_sel`  out  2  00 = ALU, 01 = memory data, 10 = PC+4.
- `state`  out  3  current state, for debug.
- `instret`  out  32  retired-instruction count.
- `trap`  out  1  illegal-instruction trap (see Configuration).

## Operation

State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5.

Legal opcodes: 0110011 (R), 0010011 (OP-IMM), 0000011 (LOAD), 0100011 (STORE), 1100011 (BRANCH), 0110111 (LUI), 0010111 (AUIPC), 1101111 (JAL), 1100111 (JALR). Every other value is illegal.

State behaviour:
- FETCH: `mem_req`=1, `mem_addr_sel`=0, `mem_we`=0. When `mem_ready` is high, `ir_we`=1 in that same cycle and the next state is DECODE. Otherwise the FSM stays in FETCH.
- DECODE: no strobes. Next state is EXEC; an illegal opcode goes to TRAP when the macro is defined.
- EXEC, selects by opcode:
  - R: a=rs1, b=rs2.
  - OP-IMM, LOAD, STORE, JALR: a=rs1, b=imm.
  - LUI: a=zero, b=imm.
  - AUIPC: a=PC, b=imm.
  - BRANCH: a=rs1, b=rs2.
- EXEC, transitions:
  - R, OP-IMM, LUI, AUIPC go to WB.
  - LOAD and STORE go to MEM.
  - BRANCH: `pc_we`=1, `pc_src`=01 if `br_taken` else 00, then FETCH.
  - JAL: `reg_we`=1, `wb_sel`=10, `pc_we`=1, `pc_src`=01, then FETCH.
  - JALR: `reg_we`=1, `wb_sel`=10, `pc_we`=1, `pc_src`=10, then FETCH.
  - Illegal (macro undefined): WB with `reg_we` suppressed.
- MEM: `mem_req`=1, `mem_addr_sel`=1, `mem_we`=1 for STORE. The ALU selects from EXEC are held. The FSM stays in MEM until `mem_ready`. Then LOAD goes to WB; STORE asserts `pc_we`=1, `pc_src`=00 and goes to FETCH.
- WB: `reg_we`=1 except for illegal opcodes. `wb_sel`=01 for LOAD, else 00. `pc_we`=1, `pc_src`=00. Next state is FETCH.
- TRAP: all strobes are 0 and `trap`=1. The FSM stays in TRAP until `rst`.

Retired-instruction counter:
- `instret` increments by 1 on every cycle with `pc_we`=1.
- It wraps from 0xFFFFFFFF to 0 with no flag.

PC stability: the PC is not written before the instruction's final cycle, so PC-relative selects always see the current instruction's address.

## Timing

- All outputs are combinational from the registered `state` plus `opcode`, `br_taken` and `mem_ready` (Moore/Mealy mix). `ir_we` is qualified by `mem_ready`.
- While `rst`=1, every strobe (`mem_req`, `mem_we`, `ir_we`, `pc_we`, `reg_we`) is forced to 0.
- Reset values: `state`=0 (FETCH), `instret`=0, `trap`=0, selects=0.
- Reset asserted mid-instruction, including during a MEM wait, returns the FSM to FETCH on the next edge. No write strobe is issued in the reset cycle.
- Latency per instruction with `mem_ready` tied high:
  - ALU, LUI, AUIPC: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BRANCH, JAL, JALR: 3 cycles.
- Each cycle with `mem_ready` low in FETCH or MEM adds exactly 1 cycle.
- `mem_req` stays high continuously through a wait. `mem_we`/`mem_addr_sel` do not change while `mem_req` is pending.

## Configuration

`MCTRL_ILLEGAL_TRAP_EN`:
- Defined: an illegal opcode in DECODE moves the FSM to TRAP. `trap` goes high from the next cycle and stays high until reset. `instret` does not increment for that instruction.
- Undefined: TRAP is unreachable and `trap` is tied 0. An illegal opcode executes as a NOP: DECODE→EXEC→WB with `reg_we`=0, PC+4, and `instret` increments.

## Test plan

- Reset, then R-type with `mem_ready`=1: state sequence 0,1,2,4,0. `reg_we`=1 with `wb_sel`=00 only in WB. `instret` goes 0→1.
- LOAD with `mem_ready` low for 3 MEM cycles: `mem_req`=1 and `mem_addr_sel`=1 for 4 cycles. WB has `wb_sel`=01. Total 8 cycles.
- BRANCH with `br_taken`=1, then again with `br_taken`=0: `pc_src`=01, then 00, in EXEC. 3 cycles each, no `reg_we`.
- JALR: in EXEC, `reg_we`=1, `wb_sel`=10, `pc_src`=10, `alu_a_sel`=00, `alu_b_sel`=1.
- Opcode 0000000 with the macro defined: `trap`=1 from cycle 3 and held for 10 cycles, `instret` unchanged. Without the macro: WB with `reg_we`=0 and `instret` increments.
- `rst` pulsed during the STORE MEM wait: no `mem_we`/`pc_we` pulse, state 0 next cycle, `instret`=0. Separately, preload `instret` near 0xFFFFFFFF and retire one instruction: it wraps to 0.
